// File: rtl/vidmode_seq.sv
// Video mode sequencer: a debounced push-button steps through a programmable
// modeline table; the raster timing generator switches modes only at frame boundaries.
module vidmode_seq #(
  parameter int NUM_MODES  = 4,
  parameter int CW         = 12,
  parameter int DEB_CYCLES = 65535,
  parameter int MW         = 2,
  // Modeline loaded into every table entry and the shadow at reset (640x480 by default)
  parameter int RST_HDISP  = 640,
  parameter int RST_HSTART = 656,
  parameter int RST_HEND   = 752,
  parameter int RST_HTOT   = 800,
  parameter int RST_VDISP  = 480,
  parameter int RST_VSTART = 490,
  parameter int RST_VEND   = 492,
  parameter int RST_VTOT   = 525
) (
  input  logic          sys_clk,
  input  logic          sys_reset,
  input  logic          but_advance,
  input  logic          cfg_wr,
  input  logic [MW-1:0] cfg_mode,
  input  logic [3:0]    cfg_field,
  input  logic [CW-1:0] cfg_data,
  output logic [MW-1:0] mode_sel,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic          linestart,
  output logic          framestart,
  output logic          switching
);

  localparam int DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

  typedef enum logic [3:0] {
    F_HDISP  = 4'd0, F_HSTART = 4'd1, F_HEND = 4'd2, F_HTOT = 4'd3, F_HSI = 4'd4,
    F_VDISP  = 4'd5, F_VSTART = 4'd6, F_VEND = 4'd7, F_VTOT = 4'd8, F_VSI = 4'd9
  } field_e;

  typedef struct packed {
    logic [CW-1:0] hdisp;
    logic [CW-1:0] hstart;
    logic [CW-1:0] hend;
    logic [CW-1:0] htot;
    logic          hsi;
    logic [CW-1:0] vdisp;
    logic [CW-1:0] vstart;
    logic [CW-1:0] vend;
    logic [CW-1:0] vtot;
    logic          vsi;
  } modeline_t;

  localparam modeline_t RST_LINE = '{
    hdisp:  CW'(RST_HDISP),  hstart: CW'(RST_HSTART), hend: CW'(RST_HEND),
    htot:   CW'(RST_HTOT),   hsi:    1'b1,
    vdisp:  CW'(RST_VDISP),  vstart: CW'(RST_VSTART), vend: CW'(RST_VEND),
    vtot:   CW'(RST_VTOT),   vsi:    1'b1
  };

  // ---------------- button synchroniser and debouncer ----------------
  logic          sync_q1, sync_q2, deb_level;
  logic [DW-1:0] deb_cnt;
  logic          deb_flip, press;

  always_comb begin
    deb_flip = (sync_q2 != deb_level) && (deb_cnt == DW'(DEB_CYCLES - 1));
    press    = deb_flip && sync_q2;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (!sys_reset) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      sync_q1 <= but_advance;
      sync_q2 <= sync_q1;
      if (sync_q2 == deb_level || deb_flip) deb_cnt <= '0;
      else                                  deb_cnt <= deb_cnt + 1'b1;
      if (deb_flip) deb_level <= sync_q2;
    end
  end

  // ---------------- modeline table ----------------
  modeline_t table_q [NUM_MODES];
  logic      wr_ok;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ok = cfg_wr && (int'(cfg_mode) < NUM_MODES) && (cfg_field <= 4'd9);
    if ((cfg_field == F_HTOT || cfg_field == F_VTOT) && cfg_data < CW'(2)) wr_ok = 1'b0;
  end

  // NOTE: the table is reset on purpose: every entry must hold a usable modeline after reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_reset) begin
      for (int i = 0; i < NUM_MODES; i++) table_q[i] <= RST_LINE;
    end else if (wr_ok) begin
      case (cfg_field)
        F_HDISP:  table_q[cfg_mode].hdisp  <= cfg_data;
        F_HSTART: table_q[cfg_mode].hstart <= cfg_data;
        F_HEND:   table_q[cfg_mode].hend   <= cfg_data;
        F_HTOT:   table_q[cfg_mode].htot   <= cfg_data;
        F_HSI:    table_q[cfg_mode].hsi    <= cfg_data[0];
        F_VDISP:  table_q[cfg_mode].vdisp  <= cfg_data;
        F_VSTART: table_q[cfg_mode].vstart <= cfg_data;
        F_VEND:   table_q[cfg_mode].vend   <= cfg_data;
        F_VTOT:   table_q[cfg_mode].vtot   <= cfg_data;
        F_VSI:    table_q[cfg_mode].vsi    <= cfg_data[0];
        default:  ;
      endcase
    end
  end

  // ---------------- raster counters and mode switch ----------------
  modeline_t     sh_q, sh_nxt;
  logic [MW-1:0] pend_q, pend_nxt, mode_nxt;
  logic [CW-1:0] h_nxt, v_nxt;
  logic          h_last, v_last, boundary;

  always_comb begin
    h_last   = hcount >= sh_q.htot - 1'b1;
    v_last   = vcount >= sh_q.vtot - 1'b1;
    boundary = h_last && v_last;
    h_nxt    = h_last ? '0 : hcount + 1'b1;
    v_nxt    = vcount;
    if (h_last) v_nxt = v_last ? '0 : vcount + 1'b1;
    mode_nxt = mode_sel;
    sh_nxt   = sh_q;
    // The shadow reads the pre-edge table, so a write on the boundary cycle waits a frame
    if (boundary) begin
      mode_nxt = pend_q;
      sh_nxt   = table_q[pend_q];
    end
    pend_nxt = pend_q;
    if (press) pend_nxt = (pend_q == MW'(NUM_MODES - 1)) ? '0 : pend_q + 1'b1;
  end

  // Flags are computed from next-state values so they line up with the counters they describe
  always_ff @(posedge sys_clk) begin
    if (!sys_reset) begin
      sh_q       <= RST_LINE;
      mode_sel   <= '0;
      pend_q     <= '0;
      hcount     <= '0;
      vcount     <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      blank      <= 1'b0;
      linestart  <= 1'b0;
      framestart <= 1'b0;
      switching  <= 1'b0;
    end else begin
      sh_q       <= sh_nxt;
      mode_sel   <= mode_nxt;
      pend_q     <= pend_nxt;
      hcount     <= h_nxt;
      vcount     <= v_nxt;
      hsync      <= ((h_nxt >= sh_nxt.hstart) && (h_nxt < sh_nxt.hend)) ^ sh_nxt.hsi;
      vsync      <= ((v_nxt >= sh_nxt.vstart) && (v_nxt < sh_nxt.vend)) ^ sh_nxt.vsi;
      blank      <= (h_nxt >= sh_nxt.hdisp) || (v_nxt >= sh_nxt.vdisp);
      linestart  <= h_last;
      framestart <= boundary;
      switching  <= pend_nxt != mode_nxt;
    end
  end

endmodule

// File: doc/vidmode_seq.md
VIDMODE_SEQ -- requirements
Module: vidmode_seq

Interface
REQ-001 Parameter NUM_MODES, default 4, number of modeline table entries (2..16).
REQ-002 Parameter CW, default 12, width of all timing fields and counters.
REQ-003 Parameter DEB_CYCLES, default 65535, button-stable cycles required before a level is accepted.
REQ-004 Parameter MW, default 2, mode index width; SHALL be ceil(log2(NUM_MODES)).
REQ-005 sys_clk  in  1  single clock (pixel clock); all logic on rising edge.
REQ-006 sys_reset  in  1  reset; synchronous and active-low.
REQ-007 but_advance  in  1  raw asynchronous push-button; high = pressed.
REQ-008 cfg_wr  in  1  table write strobe, one entry field per cycle.
REQ-009 cfg_mode  in  MW  table entry index to write.
REQ-010 cfg_field  in  4  field select: 0 hdisp, 1 hstart, 2 hend, 3 htot, 4 hsi, 5 vdisp, 6 vstart, 7 vend, 8 vtot, 9 vsi.
REQ-011 cfg_data  in  CW  field value; hsi/vsi use bit 0.
REQ-012 mode_sel  out  MW  index of the mode currently displayed.
REQ-013 hcount, vcount  out  CW each  current pixel/line position.
REQ-014 hsync, vsync  out  1 each  sync outputs, polarity per active hsi/vsi.
REQ-015 blank  out  1  high outside the display area.
REQ-016 linestart, framestart  out  1 each  single-cycle pulses.
REQ-017 switching  out  1  high while a mode change is pending.

Function
REQ-018 but_advance SHALL pass a 2-flop synchroniser, then a debouncer that accepts a new level only after DEB_CYCLES consecutive identical synchronised samples.
REQ-019 Each accepted 0->1 transition SHALL advance pending index by 1, wrapping NUM_MODES-1 -> 0; the second and later presses before a frame boundary SHALL advance from the pending index, not from mode_sel.
REQ-020 switching SHALL be 1 whenever pending index != mode_sel.
REQ-021 A table write SHALL occur when cfg_wr=1, cfg_mode < NUM_MODES and cfg_field <= 9; otherwise it is ignored; a write of htot or vtot with value < 2 SHALL be ignored.
REQ-022 Active timing SHALL come from shadow registers, never directly from the table.
REQ-023 Frame boundary = cycle with hcount==htot-1 and vcount==vtot-1 (shadow values); on the following edge: counters -> 0, mode_sel <- pending, shadow <- table[pending].
REQ-024 A table write in the same cycle as a frame boundary SHALL NOT reach the shadow until the next boundary; writes to the displayed mode take effect only at the next boundary.
REQ-025 hcount SHALL count 0..htot-1 and wrap to 0; vcount SHALL increment on each hcount wrap and wrap 0 after vtot-1.
REQ-026 Sync region: hstart <= hcount < hend (vstart <= vcount < vend, unsigned compare); hsync = in_region XOR hsi (si=1 is active-low); same rule for vsync.
REQ-027 blank = (hcount >= hdisp) OR (vcount >= vdisp).
REQ-028 All outputs SHALL be registered and mutually aligned: hsync/vsync/blank/linestart/framestart in a cycle describe the hcount/vcount presented in that same cycle.
REQ-029 linestart = 1 in the cycle hcount==0 entered by wrap; framestart = 1 when both counters are 0 entered by wrap; never asserted in the first cycle after reset.
REQ-030 Out-of-range shadow values (e.g. hstart >= htot) SHALL not stall counters; only the corresponding flag never asserts.

Reset
REQ-031 While sys_reset=0 at an edge: all table entries <- 640/656/752/800/hsi=1, 480/490/492/525/vsi=1; shadow <- same; mode_sel, pending, hcount, vcount <- 0; debouncer accepted level <- 0; switching, blank, linestart, framestart <- 0; hsync, vsync <- 1.
REQ-032 Reset mid-frame or mid-switch SHALL discard the pending change and any partial debounce count.

Verification
REQ-033 Reset, run 800*525 cycles -> framestart exactly once, at cycle 420000; hsync low for hcount 656..751; blank at hcount 640.
REQ-034 Write mode 1 = 8/9/10/12/si0, 4/5/6/7/si0; one clean press (DEB_CYCLES=4) -> switching=1 until boundary, then mode_sel=1, line period 12, vsync high only at vcount 5, frame 84 cycles.
REQ-035 Three presses in one frame with NUM_MODES=4 from mode 0 -> at boundary mode_sel=3; four presses -> mode_sel=0, switching cleared.
REQ-036 Button glitch shorter than DEB_CYCLES -> no advance, switching stays 0.
REQ-037 Write htot=1, cfg_field=12, cfg_mode=NUM_MODES -> table unchanged; write hdisp=100 to displayed mode on boundary cycle -> old hdisp kept one frame, 100 thereafter.
REQ-038 Assert reset at hcount=300 with switch pending -> next cycle counters 0, mode_sel=0, switching=0, hsync=vsync=1.
